// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the buffered UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    typedef struct packed {
        logic       brk;
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_entry_t;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    // Bit times in one character: start + data + optional parity + stop.
    function automatic logic [3:0] frame_bits(input logic [1:0] dbits, input logic par_en);
        return 4'd7 + {2'b00, dbits} + {3'b000, par_en};
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {STAGES{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
        end
    end

    assign dout = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampled UART frame receiver: start validation, 5-8 data bits, optional parity,
// stop check and break detection. Emits one entry with a single-cycle valid per frame.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       uart_clk,
    input  logic       uart_rst_n,
    input  logic       sample_tick,
    input  logic       rx,
    input  logic [1:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    output rx_entry_t  entry,
    output logic       entry_valid,
    output logic [3:0] char_bits,
    output logic       active
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    rx_state_e      state_reg, state_next;
    logic [TW-1:0]  tick_reg, tick_next;
    logic [2:0]     bit_reg, bit_next;
    logic [7:0]     data_reg, data_next;
    logic           par_reg, par_next;
    logic           perr_reg, perr_next;
    logic [1:0]     dbits_reg, dbits_next;
    logic           pen_reg, pen_next;
    logic           podd_reg, podd_next;
    logic           stop_ferr, stop_brk;

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            state_reg <= ST_IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            data_reg  <= '0;
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
            dbits_reg <= DBITS_5;
            pen_reg   <= 1'b0;
            podd_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            data_reg  <= data_next;
            par_reg   <= par_next;
            perr_reg  <= perr_next;
            dbits_reg <= dbits_next;
            pen_reg   <= pen_next;
            podd_reg  <= podd_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        tick_next   = tick_reg;
        bit_next    = bit_reg;
        data_next   = data_reg;
        par_next    = par_reg;
        perr_next   = perr_reg;
        dbits_next  = dbits_reg;
        pen_next    = pen_reg;
        podd_next   = podd_reg;
        entry_valid = 1'b0;
        stop_ferr   = 1'b0;
        stop_brk    = 1'b0;

        if (sample_tick) begin
            unique case (state_reg)
                ST_IDLE: begin
                    // Format is frozen here so register writes mid-frame cannot corrupt it.
                    if (!rx) begin
                        state_next = ST_START;
                        tick_next  = '0;
                        bit_next   = '0;
                        data_next  = '0;
                        par_next   = 1'b0;
                        perr_next  = 1'b0;
                        dbits_next = cfg_data_bits;
                        pen_next   = cfg_parity_en;
                        podd_next  = cfg_parity_odd;
                    end
                end
                ST_START: begin
                    if (tick_reg == TICK_MID) begin
                        tick_next  = '0;
                        state_next = rx ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next          = '0;
                        data_next[bit_reg] = rx;
                        if (bit_reg == 3'd4 + {1'b0, dbits_reg}) begin
                            state_next = pen_reg ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_next = bit_reg + 3'd1;
                        end
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next  = '0;
                        par_next   = rx;
                        perr_next  = (^data_reg) ^ rx ^ podd_reg;
                        state_next = ST_STOP;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next   = '0;
                        entry_valid = 1'b1;
                        stop_ferr   = !rx;
                        // par_reg stays 0 when no parity bit is present.
                        stop_brk    = !rx && (data_reg == 8'h00) && !par_reg;
                        state_next  = stop_brk ? ST_BRK_WAIT : ST_IDLE;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                ST_BRK_WAIT: begin
                    if (rx) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        entry      = '0;
        entry.brk  = stop_brk;
        entry.perr = perr_reg;
        entry.ferr = stop_ferr;
        entry.data = data_reg;
    end

    assign char_bits = frame_bits(dbits_reg, pen_reg);
    assign active    = (state_reg != ST_IDLE);

endmodule

// File: rtl/uart_rx_buffered.sv
// Buffered UART receiver: synchroniser, frame receiver and a show-ahead FIFO with
// per-character error tags, fill level, threshold, character timeout and sticky overrun.
module uart_rx_buffered
    import uart_rx_pkg::*;
#(
    parameter int  FIFO_DEPTH    = 16,
    parameter int  SYNC_STAGES   = 3,
    parameter int  OVERSAMPLE    = 16,
    parameter int  TIMEOUT_CHARS = 4,
    localparam int LEVEL_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               uart_clk,
    input  logic               uart_rst_n,
    input  logic               sample_tick,
    input  logic               rx_serial,
    input  logic [1:0]         cfg_data_bits,
    input  logic               cfg_parity_en,
    input  logic               cfg_parity_odd,
    input  logic [LEVEL_W-1:0] cfg_rx_thresh,
    input  logic               fifo_reset,
    input  logic               ovr_clr,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic [2:0]         rd_status,
    output logic               rd_empty,
    output logic [LEVEL_W-1:0] rx_level,
    output logic               rx_thresh_hit,
    output logic               rx_timeout,
    output logic               overrun_error,
    output logic               rx_active
);

    localparam int PTR_W = LEVEL_W - 1;
    localparam int TO_W  = $clog2(TIMEOUT_CHARS * 12 * OVERSAMPLE + 1);

    logic               rx_sync;
    rx_entry_t          frame_entry;
    logic               frame_valid;
    logic [3:0]         char_bits;
    logic               frame_active;

    rx_entry_t          mem [FIFO_DEPTH];
    rx_entry_t          head;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LEVEL_W-1:0] level_reg;
    logic               ovr_reg;
    logic [TO_W-1:0]    to_cnt_reg;
    logic [TO_W-1:0]    to_limit;
    logic               empty, full, push, pop, drop;

    bit_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (uart_clk),
        .rst_n (uart_rst_n),
        .din   (rx_serial),
        .dout  (rx_sync)
    );

    uart_rx_frame #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_frame (
        .uart_clk       (uart_clk),
        .uart_rst_n     (uart_rst_n),
        .sample_tick    (sample_tick),
        .rx             (rx_sync),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .entry          (frame_entry),
        .entry_valid    (frame_valid),
        .char_bits      (char_bits),
        .active         (frame_active)
    );

    assign empty = (level_reg == '0);
    assign full  = (level_reg == LEVEL_W'(FIFO_DEPTH));
    assign pop   = rd_en && !empty;
    // A full FIFO still accepts a character when the head leaves in the same cycle.
    assign push  = frame_valid && (!full || pop);
    assign drop  = frame_valid && !push;

    always_ff @(posedge uart_clk) begin
        if (push && !fifo_reset) begin
            mem[wr_ptr_reg] <= frame_entry;
        end
    end

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (fifo_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop) begin
                level_reg <= level_reg + LEVEL_W'(1);
            end else if (pop && !push) begin
                level_reg <= level_reg - LEVEL_W'(1);
            end
        end
    end

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            ovr_reg <= 1'b0;
        end else if (drop) begin
            ovr_reg <= 1'b1;
        end else if (ovr_clr || fifo_reset) begin
            ovr_reg <= 1'b0;
        end
    end

    // Timeout length follows the format of the last character received.
    assign to_limit = TO_W'(TIMEOUT_CHARS * OVERSAMPLE) * TO_W'(char_bits);

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            to_cnt_reg <= '0;
        end else if (fifo_reset || push || pop || empty) begin
            to_cnt_reg <= '0;
        end else if (sample_tick && !frame_active && (to_cnt_reg < to_limit)) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end

    assign head          = mem[rd_ptr_reg];
    assign rd_data       = empty ? 8'h00 : head.data;
    assign rd_status     = empty ? 3'b000 : {head.brk, head.perr, head.ferr};
    assign rd_empty      = empty;
    assign rx_level      = level_reg;
    assign rx_thresh_hit = (cfg_rx_thresh != '0) && (level_reg >= cfg_rx_thresh);
    assign rx_timeout    = (to_cnt_reg >= to_limit);
    assign overrun_error = ovr_reg;
    assign rx_active     = frame_active;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: directed vector table, hand sequences
// for multi-cycle corners, and randomized characters against a frame-level model.
module tb_uart_rx_buffered;

    localparam int LEVEL_W = 5;

    logic               uart_clk = 1'b0;
    logic               uart_rst_n = 1'b0;
    logic               sample_tick = 1'b0;
    logic               rx_serial = 1'b1;
    logic [1:0]         cfg_data_bits = 2'd3;
    logic               cfg_parity_en = 1'b0;
    logic               cfg_parity_odd = 1'b0;
    logic [LEVEL_W-1:0] cfg_rx_thresh = '0;
    logic               fifo_reset = 1'b0;
    logic               ovr_clr = 1'b0;
    logic               rd_en = 1'b0;
    logic [7:0]         rd_data;
    logic [2:0]         rd_status;
    logic               rd_empty;
    logic [LEVEL_W-1:0] rx_level;
    logic               rx_thresh_hit;
    logic               rx_timeout;
    logic               overrun_error;
    logic               rx_active;

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] q[$];

    uart_rx_buffered dut (
        .uart_clk       (uart_clk),
        .uart_rst_n     (uart_rst_n),
        .sample_tick    (sample_tick),
        .rx_serial      (rx_serial),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_rx_thresh  (cfg_rx_thresh),
        .fifo_reset     (fifo_reset),
        .ovr_clr        (ovr_clr),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_status      (rd_status),
        .rd_empty       (rd_empty),
        .rx_level       (rx_level),
        .rx_thresh_hit  (rx_thresh_hit),
        .rx_timeout     (rx_timeout),
        .overrun_error  (overrun_error),
        .rx_active      (rx_active)
    );

    always #5 uart_clk = ~uart_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] dbits;
        bit         pen;
        bit         odd;
        logic [7:0] data;
        bit         pbit;
        bit         stopv;
        logic [7:0] exp_data;
        logic [2:0] exp_status;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // One sample tick; the line value is applied early enough to clear the synchroniser.
    task automatic do_tick(input logic v, input logic rd);
        rx_serial = v;
        repeat (3) @(posedge uart_clk);
        #1;
        sample_tick = 1'b1;
        rd_en = rd;
        @(posedge uart_clk);
        #1;
        sample_tick = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic ticks(input logic v, input int n);
        for (int i = 0; i < n; i++) do_tick(v, 1'b0);
    endtask

    // Stop bit is driven for 9 ticks (through its mid-bit sample), then tail idle ticks.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pbit,
                              input bit stopv, input int tail, input bit rd_at_stop, input bit scramble);
        logic [1:0] sv_bits;
        logic sv_pen, sv_odd;
        sv_bits = cfg_data_bits;
        sv_pen  = cfg_parity_en;
        sv_odd  = cfg_parity_odd;
        do_tick(1'b0, 1'b0);
        if (scramble) begin
            cfg_data_bits  = 2'($urandom);
            cfg_parity_en  = 1'($urandom);
            cfg_parity_odd = 1'($urandom);
        end
        ticks(1'b0, 15);
        for (int k = 0; k < nbits; k++) ticks(d[k], 16);
        if (pen) ticks(pbit, 16);
        ticks(stopv, 8);
        do_tick(stopv, rd_at_stop);
        ticks(1'b1, tail);
        cfg_data_bits  = sv_bits;
        cfg_parity_en  = sv_pen;
        cfg_parity_odd = sv_odd;
    endtask

    function automatic bit par_exp(input logic [7:0] v, input bit odd);
        return odd ? ~(^v) : (^v);
    endfunction

    function automatic logic [10:0] model(input logic [7:0] d, input int nbits, input bit pen,
                                          input bit odd, input bit pbit, input bit stopv);
        logic [7:0] v;
        bit perr, ferr, brk;
        v    = d & 8'((1 << nbits) - 1);
        perr = pen && (pbit != par_exp(v, odd));
        ferr = !stopv;
        brk  = ferr && (v == 8'h00) && !(pen && pbit);
        return {brk, perr, ferr, v};
    endfunction

    task automatic pop_check(input string name, input logic [10:0] exp);
        chk({name, ".data"}, 32'(rd_data), 32'(exp[7:0]));
        chk({name, ".status"}, 32'(rd_status), 32'(exp[10:8]));
        rd_en = 1'b1;
        @(posedge uart_clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] b, input bit pen, input bit odd);
        cfg_data_bits  = b;
        cfg_parity_en  = pen;
        cfg_parity_odd = odd;
    endtask

    initial begin
        logic [10:0] e;
        int nb;
        logic [7:0] d;
        bit pen, odd, pbit, stopv;

        vecs[0] = '{2'd3, 0, 0, 8'h81, 0, 1, 8'h81, 3'b000};
        vecs[1] = '{2'd2, 1, 1, 8'h55, 0, 1, 8'h55, 3'b010};
        vecs[2] = '{2'd2, 1, 1, 8'h2A, 0, 1, 8'h2A, 3'b000};
        vecs[3] = '{2'd0, 1, 0, 8'hFF, 1, 1, 8'h1F, 3'b000};
        vecs[4] = '{2'd1, 0, 0, 8'h3F, 0, 0, 8'h3F, 3'b001};
        vecs[5] = '{2'd3, 1, 0, 8'h00, 0, 0, 8'h00, 3'b101};
        vecs[6] = '{2'd3, 1, 0, 8'h00, 1, 0, 8'h00, 3'b011};
        vecs[7] = '{2'd0, 0, 0, 8'hF5, 0, 1, 8'h15, 3'b000};
        vecs[8] = '{2'd3, 1, 1, 8'h00, 1, 1, 8'h00, 3'b000};
        vecs[9] = '{2'd1, 0, 0, 8'h00, 0, 0, 8'h00, 3'b101};

        // Reset state
        repeat (2) @(posedge uart_clk);
        #1;
        chk("reset.rd_empty", 32'(rd_empty), 32'd1);
        chk("reset.rd_data", 32'(rd_data), 32'd0);
        chk("reset.rd_status", 32'(rd_status), 32'd0);
        chk("reset.rx_level", 32'(rx_level), 32'd0);
        chk("reset.flags", {28'd0, rx_thresh_hit, rx_timeout, overrun_error, rx_active}, 32'd0);
        uart_rst_n = 1'b1;
        ticks(1'b1, 4);

        // 8N1 0xA5 then 0x3C with threshold 2
        set_cfg(2'd3, 0, 0);
        cfg_rx_thresh = 5'd2;
        send_frame(8'hA5, 8, 0, 0, 1, 7, 0, 0);
        chk("a5.level", 32'(rx_level), 32'd1);
        chk("a5.thresh", 32'(rx_thresh_hit), 32'd0);
        send_frame(8'h3C, 8, 0, 0, 1, 7, 0, 0);
        chk("3c.level", 32'(rx_level), 32'd2);
        chk("3c.thresh", 32'(rx_thresh_hit), 32'd1);
        pop_check("a5", {3'b000, 8'hA5});
        pop_check("3c", {3'b000, 8'h3C});
        chk("a53c.level_after", 32'(rx_level), 32'd0);
        chk("a53c.empty_after", 32'(rd_empty), 32'd1);
        cfg_rx_thresh = '0;

        // Directed table; cfg inputs are scrambled mid-frame
        for (int i = 0; i < 10; i++) begin
            set_cfg(vecs[i].dbits, vecs[i].pen, vecs[i].odd);
            send_frame(vecs[i].data, int'(vecs[i].dbits) + 5, vecs[i].pen, vecs[i].pbit,
                       vecs[i].stopv, 7, 0, 1);
            ticks(1'b1, 2);
            chk($sformatf("vec%0d.level", i), 32'(rx_level), 32'd1);
            pop_check($sformatf("vec%0d", i), {vecs[i].exp_status, vecs[i].exp_data});
            chk($sformatf("vec%0d.empty", i), 32'(rd_empty), 32'd1);
        end

        // Line held low for two character times: one break entry only
        set_cfg(2'd3, 0, 0);
        ticks(1'b0, 320);
        chk("brk.level_low", 32'(rx_level), 32'd1);
        chk("brk.active_low", 32'(rx_active), 32'd1);
        ticks(1'b1, 3);
        chk("brk.level_high", 32'(rx_level), 32'd1);
        chk("brk.active_high", 32'(rx_active), 32'd0);
        pop_check("brk", {3'b101, 8'h00});

        // Glitches shorter than half a bit are rejected
        do_tick(1'b0, 1'b0);
        chk("glitch1.active", 32'(rx_active), 32'd1);
        ticks(1'b1, 20);
        chk("glitch1.active_end", 32'(rx_active), 32'd0);
        chk("glitch1.empty", 32'(rd_empty), 32'd1);
        ticks(1'b0, 3);
        ticks(1'b1, 20);
        chk("glitch3.empty", 32'(rd_empty), 32'd1);
        ticks(1'b0, 7);
        ticks(1'b1, 20);
        chk("glitch7.empty", 32'(rd_empty), 32'd1);

        // Reset asserted mid-frame loses the partial character
        ticks(1'b0, 16);
        ticks(1'b1, 30);
        chk("midrst.active_before", 32'(rx_active), 32'd1);
        #2 uart_rst_n = 1'b0;
        #1;
        chk("midrst.active", 32'(rx_active), 32'd0);
        @(posedge uart_clk);
        #1 uart_rst_n = 1'b1;
        ticks(1'b1, 200);
        chk("midrst.empty", 32'(rd_empty), 32'd1);

        // Character timeout after 4 * 10 * 16 idle ticks
        set_cfg(2'd3, 0, 0);
        send_frame(8'h5A, 8, 0, 0, 1, 0, 0, 0);
        ticks(1'b1, 639);
        chk("timeout.before", 32'(rx_timeout), 32'd0);
        do_tick(1'b1, 1'b0);
        chk("timeout.exact", 32'(rx_timeout), 32'd1);
        pop_check("timeout", {3'b000, 8'h5A});
        chk("timeout.cleared", 32'(rx_timeout), 32'd0);
        chk("timeout.empty", 32'(rd_empty), 32'd1);

        // fifo_reset clears the contents
        send_frame(8'h11, 8, 0, 0, 1, 7, 0, 0);
        send_frame(8'h22, 8, 0, 0, 1, 7, 0, 0);
        chk("fiforst.level_before", 32'(rx_level), 32'd2);
        fifo_reset = 1'b1;
        @(posedge uart_clk);
        #1 fifo_reset = 1'b0;
        chk("fiforst.level", 32'(rx_level), 32'd0);
        chk("fiforst.empty", 32'(rd_empty), 32'd1);
        chk("fiforst.rd_data", 32'(rd_data), 32'd0);

        // Overrun: 17 characters into 16 entries
        q.delete();
        cfg_rx_thresh = 5'd16;
        for (int i = 0; i < 17; i++) begin
            d = 8'((i * 37 + 11) & 8'hFF);
            send_frame(d, 8, 0, 0, 1, 2, 0, 0);
            if (q.size() < 16) q.push_back({3'b000, d});
        end
        chk("ovr.level", 32'(rx_level), 32'd16);
        chk("ovr.flag", 32'(overrun_error), 32'd1);
        chk("ovr.thresh16", 32'(rx_thresh_hit), 32'd1);
        cfg_rx_thresh = '0;
        #1;
        chk("ovr.thresh0", 32'(rx_thresh_hit), 32'd0);
        chk("ovr.head", 32'(rd_data), 32'(q[0][7:0]));
        ovr_clr = 1'b1;
        @(posedge uart_clk);
        #1 ovr_clr = 1'b0;
        chk("ovr.cleared", 32'(overrun_error), 32'd0);
        send_frame(8'hE7, 8, 0, 0, 1, 2, 1, 0);
        void'(q.pop_front());
        q.push_back({3'b000, 8'hE7});
        chk("ovr.rdwr_flag", 32'(overrun_error), 32'd0);
        chk("ovr.rdwr_level", 32'(rx_level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            e = q.pop_front();
            pop_check($sformatf("ovr.entry%0d", i), e);
        end
        chk("ovr.empty", 32'(rd_empty), 32'd1);

        // Randomized characters against the model
        for (int b = 0; b < 4; b++) begin
            int n;
            n = $urandom_range(1, 4);
            q.delete();
            for (int c = 0; c < n; c++) begin
                nb    = $urandom_range(5, 8);
                pen   = 1'($urandom);
                odd   = 1'($urandom);
                d     = 8'($urandom);
                pbit  = par_exp(d & 8'((1 << nb) - 1), odd) ^ ($urandom_range(0, 3) == 0);
                stopv = ($urandom_range(0, 5) != 0);
                set_cfg(2'(nb - 5), pen, odd);
                send_frame(d, nb, pen, pbit, stopv, 7 + $urandom_range(0, 5), 0, 1);
                q.push_back(model(d, nb, pen, odd, pbit, stopv));
            end
            chk($sformatf("rand%0d.level", b), 32'(rx_level), 32'(q.size()));
            for (int c = 0; c < n; c++) begin
                e = q.pop_front();
                pop_check($sformatf("rand%0d.c%0d", b, c), e);
            end
            chk($sformatf("rand%0d.empty", b), 32'(rd_empty), 32'd1);
        end
        chk("final.overrun", 32'(overrun_error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
